sum_tx_pacer: RTL and testbench

Byte buffer and pacing stage between the row-sum controller and the UART transmitter in the FIFO-sum design. The sum controller can emit result bytes in bursts faster than one UART frame time, and the transmitter has no ready signal, so a byte arriving mid-frame would be lost. This block queues incoming bytes in a small FIFO. It releases them to the transmitter one at a time, each release followed by a fixed guard gap of at least one full frame plus one idle bit.

---
 rtl/sum_tx_pacer.sv | 105 ++++++++++
 tb/tb_sum_tx_pacer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_tx_pacer.sv
// Byte FIFO plus pacing stage between the row-sum controller and the UART transmitter.
// It releases one byte per slot; after each release it holds off for a full frame plus one idle bit.
`timescale 1ns/1ps
module sum_tx_pacer #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 9600,
    parameter int FRAME_BITS = 10,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              pi_flag,
    input  logic [7:0]        pi_data,
    output logic              po_flag,
    output logic [7:0]        po_data,
    output logic [ADDR_W:0]   fifo_cnt,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              overflow
);

    localparam int BAUD_CNT   = CLK_FREQ / UART_BPS;
    localparam int GAP_CYCLES = BAUD_CNT * (FRAME_BITS + 1);
    localparam int GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);

    // state | meaning
    // IDLE  | waiting for a queued byte; pops it as soon as one is present
    // GAP   | byte just released; counting out one frame plus an idle bit
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_GAP  = 1'b1;

    logic [7:0]       mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr;
    logic [ADDR_W:0]  rd_ptr;
    logic [0:0]       state;
    logic [GAP_W-1:0] gap_cnt;
    logic             wr_en;
    logic             rd_en;

    // Extra pointer bit distinguishes full from empty and keeps the difference valid across wrap.
    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_cnt == DEPTH_V);
    assign fifo_empty = (fifo_cnt == '0);

    assign wr_en = pi_flag && !fifo_full;
    assign rd_en = (state == ST_IDLE) && !fifo_empty;

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_W-1:0]] <= pi_data;
        end
    end

    // A write that meets a full FIFO is dropped even if a pop frees a slot on the same edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pi_flag && fifo_full) begin
                overflow <= 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
            po_flag <= 1'b0;
            po_data <= 8'h00;
        end else begin
            po_flag <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_en) begin
                        po_data <= mem[rd_ptr[ADDR_W-1:0]];
                        po_flag <= 1'b1;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_tx_pacer.sv
// Randomised and directed bench for sum_tx_pacer; a queue-based timing model predicts every output.
`timescale 1ns/1ps
module tb_sum_tx_pacer;

    localparam int DEPTH = 16;
    localparam int GAP   = 110;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       pi_flag;
    logic [7:0] pi_data;
    logic       po_flag;
    logic [7:0] po_data;
    logic [4:0] fifo_cnt;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;

    sum_tx_pacer #(
        .CLK_FREQ   (1000),
        .UART_BPS   (100),
        .FRAME_BITS (10),
        .DEPTH      (DEPTH),
        .ADDR_W     (4)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .pi_flag    (pi_flag),
        .pi_data    (pi_data),
        .po_flag    (po_flag),
        .po_data    (po_data),
        .fifo_cnt   (fifo_cnt),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: queue contents plus the earliest edge at which a pop may happen.
    logic [7:0] q[$];
    int         t;
    int         next_pop;
    logic       m_flag;
    logic [7:0] m_data;
    logic       m_ovf;
    int         max_cnt;
    int         out_t[$];
    logic [7:0] out_d[$];

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0d", tag, got, got, exp, exp, t);
        end
    endtask

    task automatic model_reset();
        q.delete();
        next_pop = t;
        m_flag   = 1'b0;
        m_data   = 8'h00;
        m_ovf    = 1'b0;
    endtask

    task automatic model_edge(input logic f, input logic [7:0] d);
        int pre;
        pre    = q.size();
        m_flag = 1'b0;
        if (pre > 0 && t >= next_pop) begin
            m_data   = q.pop_front();
            m_flag   = 1'b1;
            next_pop = t + GAP + 1;
        end
        if (f) begin
            if (pre < DEPTH) q.push_back(d);
            else             m_ovf = 1'b1;
        end
        t++;
    endtask

    task automatic check_outputs();
        check_val("po_flag",    int'(po_flag),    int'(m_flag));
        check_val("po_data",    int'(po_data),    int'(m_data));
        check_val("fifo_cnt",   int'(fifo_cnt),   q.size());
        check_val("fifo_full",  int'(fifo_full),  int'(q.size() == DEPTH));
        check_val("fifo_empty", int'(fifo_empty), int'(q.size() == 0));
        check_val("overflow",   int'(overflow),   int'(m_ovf));
        if (po_flag === 1'b1) begin
            out_t.push_back(t);
            out_d.push_back(po_data);
        end
        if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
    endtask

    task automatic step(input logic f, input logic [7:0] d);
        pi_flag = f;
        pi_data = d;
        @(posedge sys_clk);
        model_edge(f, d);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic clear_log();
        out_t.delete();
        out_d.delete();
        max_cnt = 0;
    endtask

    // Asynchronous assertion mid-cycle, release on the falling edge.
    task automatic do_reset();
        #2;
        sys_rst = 1'b1;
        pi_flag = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge sys_clk);
        check_outputs();
        sys_rst = 1'b0;
        clear_log();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        logic [7:0] wrap_d[$];

        t       = 0;
        sys_rst = 1'b1;
        pi_flag = 1'b0;
        pi_data = 8'h00;
        model_reset();
        clear_log();
        repeat (3) @(posedge sys_clk);
        #1;
        check_outputs();
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // Single byte: pulse two cycles after the write, then silence.
        base = t;
        step(1'b1, 8'hA5);
        idle(130);
        check_val("single_n", out_t.size(), 1);
        if (out_t.size() >= 1) begin
            check_val("single_lat",  out_t[0] - base, 2);
            check_val("single_data", int'(out_d[0]), 8'hA5);
        end

        // Burst of five: fixed spacing, in-order data, peak occupancy 4.
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i));
        idle(5 * (GAP + 1) + 20);
        check_val("burst_n", out_d.size(), 5);
        check_val("burst_peak", max_cnt, 4);
        for (int i = 0; i < out_d.size() && i < 5; i++) begin
            check_val("burst_data", int'(out_d[i]), i + 1);
            if (i > 0) check_val("burst_space", out_t[i] - out_t[i-1], GAP + 1);
        end

        // Eighteen writes into a 16-deep FIFO: last byte dropped, overflow sticks.
        do_reset();
        for (int i = 0; i < 18; i++) step(1'b1, 8'(8'h10 + i));
        check_val("full_flag", int'(fifo_full), 1);
        check_val("full_ovf",  int'(overflow),  1);
        idle(17 * (GAP + 1) + 20);
        check_val("full_n", out_d.size(), 17);
        for (int i = 0; i < out_d.size() && i < 17; i++)
            check_val("full_data", int'(out_d[i]), 8'h10 + i);
        check_val("full_ovf_drained", int'(overflow), 1);
        check_val("full_empty_drained", int'(fifo_empty), 1);

        // Write coinciding with an IDLE pop while three bytes are queued.
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(8'h40 + i));
        k = 0;
        while (!(t == next_pop && q.size() == 3) && k < 300) begin
            step(1'b0, 8'h00);
            k++;
        end
        check_val("simul_reach", int'(k < 300), 1);
        check_val("simul_cnt_before", int'(fifo_cnt), 3);
        step(1'b1, 8'hEE);
        check_val("simul_cnt_after", int'(fifo_cnt), 3);
        check_val("simul_pop", int'(po_flag), 1);
        idle(4 * (GAP + 1) + 20);
        check_val("simul_n", out_d.size(), 5);
        if (out_d.size() == 5) check_val("simul_last", int'(out_d[4]), 8'hEE);

        // Forty single bytes, each after the previous release: pointers wrap.
        do_reset();
        wrap_d.delete();
        for (int i = 0; i < 40; i++) begin
            wrap_d.push_back(8'(i * 7 + 3));
            check_val("wrap_empty", int'(fifo_empty), 1);
            step(1'b1, 8'(i * 7 + 3));
            k = 0;
            while (out_d.size() < i + 1 && k < 10) begin
                step(1'b0, 8'h00);
                k++;
            end
            check_val("wrap_seen", int'(k < 10), 1);
            idle(GAP + 2);
        end
        check_val("wrap_n", out_d.size(), 40);
        check_val("wrap_maxcnt", int'(max_cnt <= 1), 1);
        for (int i = 0; i < out_d.size() && i < 40; i++)
            check_val("wrap_data", int'(out_d[i]), int'(wrap_d[i]));

        // Random traffic, including overflow under sustained load.
        do_reset();
        for (int i = 0; i < 2500; i++)
            step(1'($urandom_range(0, 99) < 6), 8'($urandom));
        idle(200);

        // Reset during GAP with six bytes queued.
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom));
        idle(10);
        check_val("rst_pre_cnt", int'(fifo_cnt), 6);
        do_reset();
        idle(300);
        check_val("rst_no_out", out_d.size(), 0);
        base = t;
        step(1'b1, 8'h5A);
        idle(5);
        check_val("rst_after_n", out_d.size(), 1);
        if (out_t.size() == 1) check_val("rst_after_lat", out_t[0] - base, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
